fclk_sample_buffer: RTL

//  Stereo sample elastic buffer between the I2S receiver and the SPDIF transmitter, one L/R pair per frame.

---
 rtl/fclk_sample_buffer_if.sv | 30 +++
 rtl/fclk_sample_buffer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fclk_sample_buffer_if.sv
// Stereo sample stream between the I2S receiver, the elastic buffer and the
// SPDIF transmitter.
//   in_valid        : data_*_in carries a fresh L/R pair this frame
//   data_left_in    : left sample from the receiver
//   data_right_in   : right sample from the receiver
//   data_left_out   : registered left sample towards the transmitter
//   data_right_out  : registered right sample towards the transmitter
//   out_valid       : data_*_out is a real sample (low = mute)
// The buffer uses the slave view; whatever feeds the receiver side and
// consumes the transmitter side uses the master view.
interface fclk_sample_buffer_if #(
  parameter int WORDSIZE = 32
);
  logic                in_valid;
  logic [WORDSIZE-1:0] data_left_in;
  logic [WORDSIZE-1:0] data_right_in;
  logic [WORDSIZE-1:0] data_left_out;
  logic [WORDSIZE-1:0] data_right_out;
  logic                out_valid;

  modport master (
    output in_valid, data_left_in, data_right_in,
    input  data_left_out, data_right_out, out_valid
  );

  modport slave (
    input  in_valid, data_left_in, data_right_in,
    output data_left_out, data_right_out, out_valid
  );
endinterface

// File: rtl/fclk_sample_buffer.sv
// Stereo elastic buffer clocked by the I2S frame clock. One L/R pair may be
// written and one pair read per frame. A PRIME phase fills the buffer to
// PRIME_LEVEL before playback; underrun drops back to PRIME, overrun drops
// the incoming pair. Both events are recorded in sticky flags.
// Ports:
//   pin_i2s_fclk : frame clock, rising edge active
//   rst          : asynchronous active-high reset
//   en           : run enable; low flushes the buffer and idles (flags kept)
//   clear_flags  : synchronous clear of the sticky flags
//   bus          : sample stream (slave view of fclk_sample_buffer_if)
//   level        : fill count 0..DEPTH
//   state        : 0 IDLE, 1 PRIME, 2 RUN
//   overrun      : sticky, a pair was dropped on a full buffer
//   underrun     : sticky, a read was due in RUN with an empty buffer
module fclk_sample_buffer #(
  parameter int WORDSIZE    = 32,
  parameter int DEPTH       = 16,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                     pin_i2s_fclk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clear_flags,
  fclk_sample_buffer_if.slave      bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic [1:0]               state,
  output logic                     overrun,
  output logic                     underrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LV  = LW'(DEPTH);
  localparam logic [LW-1:0] PRIME_LV = LW'(PRIME_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                state_r, state_s;
  logic [AW-1:0]         wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]         level_r, level_s;
  logic [2*WORDSIZE-1:0] mem_r [DEPTH];
  logic [WORDSIZE-1:0]   left_r, right_r;
  logic                  valid_r, overrun_r, underrun_r;
  logic                  rd_do_s, empty_rd_s, wr_try_s, wr_acc_s, drop_s;

  // Per-frame read/write decisions and next state, all from registered state.
  always_comb begin
    rd_do_s    = 1'b0;
    empty_rd_s = 1'b0;
    wr_try_s   = 1'b0;
    wr_acc_s   = 1'b0;
    drop_s     = 1'b0;
    state_s    = state_r;
    if (en) begin
      rd_do_s    = (state_r == ST_RUN) && (level_r != {LW{1'b0}});
      empty_rd_s = (state_r == ST_RUN) && (level_r == {LW{1'b0}});
      wr_try_s   = bus.in_valid && (state_r != ST_IDLE);
      // A full buffer still accepts when a read frees a slot on the same edge.
      wr_acc_s   = wr_try_s && ((level_r < FULL_LV) || rd_do_s);
      drop_s     = wr_try_s && !wr_acc_s;
      case (state_r)
        ST_IDLE:  state_s = ST_PRIME;
        ST_PRIME: begin
          if (level_r >= PRIME_LV) state_s = ST_RUN;
          else                     state_s = ST_PRIME;
        end
        ST_RUN: begin
          if (empty_rd_s) state_s = ST_PRIME;
          else            state_s = ST_RUN;
        end
        default:  state_s = ST_IDLE;
      endcase
    end else begin
      state_s = ST_IDLE;
    end
    level_s = level_r + LW'(wr_acc_s) - LW'(rd_do_s);
  end

  // State, pointers, fill level and the registered output pair.
  always_ff @(posedge pin_i2s_fclk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      left_r   <= {WORDSIZE{1'b0}};
      right_r  <= {WORDSIZE{1'b0}};
      valid_r  <= 1'b0;
    end else if (!en) begin
      state_r  <= ST_IDLE;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      left_r   <= {WORDSIZE{1'b0}};
      right_r  <= {WORDSIZE{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      level_r <= level_s;
      if (wr_acc_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      else          wr_ptr_r <= wr_ptr_r;
      // Reading the pre-edge array gives the no-write-through behaviour.
      if (rd_do_s) begin
        {left_r, right_r} <= mem_r[rd_ptr_r];
        rd_ptr_r          <= rd_ptr_r + 1'b1;
        valid_r           <= 1'b1;
      end else begin
        left_r   <= {WORDSIZE{1'b0}};
        right_r  <= {WORDSIZE{1'b0}};
        rd_ptr_r <= rd_ptr_r;
        valid_r  <= 1'b0;
      end
    end
  end

  // Sample storage; contents need no reset since level gates every read.
  always_ff @(posedge pin_i2s_fclk) begin
    if (wr_acc_s) mem_r[wr_ptr_r] <= {bus.data_left_in, bus.data_right_in};
  end

  // Sticky flags: a new event beats clear_flags; held while disabled.
  always_ff @(posedge pin_i2s_fclk or posedge rst) begin
    if (rst) begin
      overrun_r  <= 1'b0;
      underrun_r <= 1'b0;
    end else if (en) begin
      overrun_r  <= drop_s     | (overrun_r  & ~clear_flags);
      underrun_r <= empty_rd_s | (underrun_r & ~clear_flags);
    end else begin
      overrun_r  <= overrun_r;
      underrun_r <= underrun_r;
    end
  end

  assign bus.data_left_out  = left_r;
  assign bus.data_right_out = right_r;
  assign bus.out_valid      = valid_r;
  assign level              = level_r;
  assign state              = state_r;
  assign overrun            = overrun_r;
  assign underrun           = underrun_r;
endmodule
